// File: rtl/data_memory.sv
// Main data memory behind the data cache: 64 x 32-bit blocks, one whole block per access,
// with a busywait handshake and a fixed programmable latency that models slow DRAM.
module data_memory #(
    parameter int LATENCY        = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  mem_address,
    input  logic [31:0] mem_writedata,
    output logic [31:0] mem_readdata,
    output logic        mem_busywait
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [31:0] storage [64];

    logic accept;
    logic commit;

    // Both strobes high at once is treated as no request at all.
    assign accept = (state == IDLE) && (mem_read ^ mem_write);
    assign commit = (state == BUSY) && (counter == 4'd0);

    always_comb begin
        state_next   = state;
        mem_busywait = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    mem_busywait = 1'b1;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                mem_busywait = 1'b1;
                if (commit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            counter      <= 4'd0;
            req_addr     <= 6'd0;
            req_wdata    <= 32'h0;
            req_write    <= 1'b0;
            mem_readdata <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_addr  <= mem_address;
                req_wdata <= mem_writedata;
                req_write <= mem_write;
                counter   <= 4'(LATENCY - 1);
            end else if ((state == BUSY) && (counter != 4'd0)) begin
                counter <= counter - 4'd1;
            end
            if (commit && !req_write) begin
                mem_readdata <= storage[req_addr];
            end
        end
    end

    // Reset wins over a commit in the same edge, so an aborted write never lands.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (CLEAR_ON_RESET) begin
                for (int i = 0; i < 64; i++) begin
                    storage[i] <= 32'h0;
                end
            end
        end else if (commit && req_write) begin
            storage[req_addr] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: three builds (latency 5 cleared, latency 5 retained,
// latency 1 cleared) each driven by its own set of strobes.
module tb_data_memory;

    logic        CLK;
    logic        rst   [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [5:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        busy  [3];

    int n_vec;
    int n_err;

    data_memory #(.LATENCY(5), .CLEAR_ON_RESET(1'b1)) dut_a (
        .CLK(CLK), .RESET(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_address(addr[0]), .mem_writedata(wdata[0]),
        .mem_readdata(rdata[0]), .mem_busywait(busy[0])
    );

    data_memory #(.LATENCY(5), .CLEAR_ON_RESET(1'b0)) dut_b (
        .CLK(CLK), .RESET(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_address(addr[1]), .mem_writedata(wdata[1]),
        .mem_readdata(rdata[1]), .mem_busywait(busy[1])
    );

    data_memory #(.LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_c (
        .CLK(CLK), .RESET(rst[2]), .mem_read(rd[2]), .mem_write(wr[2]),
        .mem_address(addr[2]), .mem_writedata(wdata[2]),
        .mem_readdata(rdata[2]), .mem_busywait(busy[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counts cycles with busywait high starting in the current cycle; returns at
    // negedge+1 of the first low cycle (the DONE cycle for an accepted request).
    task automatic count_busy(input int d, output int bw);
        bw = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (busy[d]) bw++;
            else break;
            @(negedge CLK);
        end
    endtask

    task automatic access(input int d, input bit w, input logic [5:0] a,
                          input logic [31:0] wd, output int bw);
        @(negedge CLK);
        rd[d]    = !w;
        wr[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        count_busy(d, bw);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(negedge CLK);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        #1;
        n_vec++;
        if (busy[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: busywait=%b readdata=%h, want busywait=0 readdata=00000000",
                     busy[0], rdata[0]);
        end
    endtask

    task automatic test_read_after_reset;
        int bw;
        access(0, 1'b0, 6'd0, 32'h0, bw);
        n_vec++;
        if (bw !== 6) begin
            n_err++;
            $display("FAIL read0_busy_cycles: got %0d, want 6", bw);
        end
        n_vec++;
        if (rdata[0] !== 32'h0) begin
            n_err++;
            $display("FAIL read0_data: got %h, want 00000000", rdata[0]);
        end
    endtask

    task automatic test_write_read;
        int bw;
        access(0, 1'b1, 6'd42, 32'hDEADBEEF, bw);
        n_vec++;
        if (bw !== 6) begin
            n_err++;
            $display("FAIL write42_busy_cycles: got %0d, want 6", bw);
        end
        access(0, 1'b0, 6'd42, 32'h0, bw);
        n_vec++;
        if (bw !== 6 || rdata[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL read42: busy=%0d data=%h, want busy=6 data=deadbeef", bw, rdata[0]);
        end
        access(0, 1'b0, 6'd41, 32'h0, bw);
        n_vec++;
        if (rdata[0] !== 32'h0) begin
            n_err++;
            $display("FAIL read41: got %h, want 00000000", rdata[0]);
        end
        access(0, 1'b0, 6'd43, 32'h0, bw);
        n_vec++;
        if (rdata[0] !== 32'h0) begin
            n_err++;
            $display("FAIL read43: got %h, want 00000000", rdata[0]);
        end
    endtask

    task automatic test_back_to_back;
        int bw;
        access(0, 1'b1, 6'd37, 32'h77665544, bw);
        access(0, 1'b0, 6'd42, 32'h0, bw);
        @(negedge CLK);
        wr[0] = 1'b1; addr[0] = 6'd5; wdata[0] = 32'h11223344;
        count_busy(0, bw);
        n_vec++;
        if (bw !== 6 || rdata[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL b2b_write: busy=%0d data=%h, want busy=6 data=deadbeef", bw, rdata[0]);
        end
        // Cache flips to the refill while still in DONE; it must not be taken yet.
        wr[0] = 1'b0; rd[0] = 1'b1; addr[0] = 6'd37; wdata[0] = 32'hFFFFFFFF;
        #1;
        n_vec++;
        if (busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_busy: got %b, want 0", busy[0]);
        end
        @(negedge CLK);
        count_busy(0, bw);
        rd[0] = 1'b0;
        n_vec++;
        if (bw !== 6 || rdata[0] !== 32'h77665544) begin
            n_err++;
            $display("FAIL b2b_read37: busy=%0d data=%h, want busy=6 data=77665544", bw, rdata[0]);
        end
        access(0, 1'b0, 6'd5, 32'h0, bw);
        n_vec++;
        if (rdata[0] !== 32'h11223344) begin
            n_err++;
            $display("FAIL b2b_read5: got %h, want 11223344", rdata[0]);
        end
    endtask

    task automatic test_reset_mid_write;
        int bw;
        access(1, 1'b1, 6'd9, 32'h0BAD0009, bw);
        access(1, 1'b0, 6'd9, 32'h0, bw);
        n_vec++;
        if (rdata[1] !== 32'h0BAD0009) begin
            n_err++;
            $display("FAIL abort_preload: got %h, want 0bad0009", rdata[1]);
        end
        @(negedge CLK);
        wr[1] = 1'b1; addr[1] = 6'd9; wdata[1] = 32'hCAFEF00D;
        repeat (3) @(negedge CLK);
        rst[1] = 1'b1; wr[1] = 1'b0;
        @(negedge CLK);
        rst[1] = 1'b0;
        #1;
        n_vec++;
        if (busy[1] !== 1'b0 || rdata[1] !== 32'h0) begin
            n_err++;
            $display("FAIL abort_state: busywait=%b readdata=%h, want 0 and 00000000",
                     busy[1], rdata[1]);
        end
        access(1, 1'b0, 6'd9, 32'h0, bw);
        n_vec++;
        if (bw !== 6 || rdata[1] !== 32'h0BAD0009) begin
            n_err++;
            $display("FAIL abort_read9: busy=%0d data=%h, want busy=6 data=0bad0009", bw, rdata[1]);
        end
    endtask

    task automatic test_both_high;
        int bw;
        @(negedge CLK);
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 6'd42; wdata[0] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (busy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL both_high_busy[%0d]: got %b, want 0", i, busy[0]);
            end
            @(negedge CLK);
        end
        rd[0] = 1'b0; wr[0] = 1'b0;
        #1;
        n_vec++;
        if (rdata[0] !== 32'h11223344) begin
            n_err++;
            $display("FAIL both_high_rdata: got %h, want 11223344", rdata[0]);
        end
        access(0, 1'b0, 6'd42, 32'h0, bw);
        n_vec++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL both_high_storage: got %h, want deadbeef", rdata[0]);
        end
    endtask

    task automatic test_latency1;
        int bw;
        access(2, 1'b1, 6'd63, 32'hA5A5A5A5, bw);
        n_vec++;
        if (bw !== 2 || rdata[2] !== 32'h0) begin
            n_err++;
            $display("FAIL lat1_write: busy=%0d data=%h, want busy=2 data=00000000", bw, rdata[2]);
        end
        @(negedge CLK);
        rd[2] = 1'b1; addr[2] = 6'd63;
        #1;
        n_vec++;
        if (busy[2] !== 1'b1) begin
            n_err++;
            $display("FAIL lat1_cycle0: busywait=%b, want 1", busy[2]);
        end
        @(negedge CLK);
        rd[2] = 1'b0; addr[2] = 6'd0;
        #1;
        n_vec++;
        if (busy[2] !== 1'b1) begin
            n_err++;
            $display("FAIL lat1_cycle1: busywait=%b, want 1", busy[2]);
        end
        @(negedge CLK);
        #1;
        n_vec++;
        if (busy[2] !== 1'b0 || rdata[2] !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL lat1_done: busywait=%b data=%h, want 0 and a5a5a5a5", busy[2], rdata[2]);
        end
        @(negedge CLK);
        #1;
        n_vec++;
        if (busy[2] !== 1'b0 || rdata[2] !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL lat1_idle: busywait=%b data=%h, want 0 and a5a5a5a5", busy[2], rdata[2]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_read_after_reset;
        test_write_read;
        test_back_to_back;
        test_reset_mid_write;
        test_both_high;
        test_latency1;
        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
